channel_register_file: RTL and testbench
========================================

CHANNEL_REGISTER_FILE -- requirements
Module: channel_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 24, width of one channel record.
REQ-002 SHALL have parameter DEPTH, default 9, number of channel records.
REQ-003 SHALL have parameter ADDR_W, default 4, address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter LANE_W, default 8, write-mask lane width; DATA_W SHALL be a multiple of LANE_W; NLANES = DATA_W/LANE_W.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic samples on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port clear, input, 1, single-cycle request to restart the zeroing sweep.
REQ-008 SHALL have port addr, input, ADDR_W, shared read/write channel address.
REQ-009 SHALL have port wr, input, 1, write strobe.
REQ-010 SHALL have port wmask, input, NLANES, per-lane write enable; bit i covers idata[i*LANE_W +: LANE_W].
REQ-011 SHALL have port idata, input, DATA_W, write data.
REQ-012 SHALL have port odata, output, DATA_W, registered read data.
REQ-013 SHALL have port init_busy, output, 1, high while the zeroing sweep runs.

Function
REQ-014 SHALL hold DEPTH records of DATA_W bits, 1 read + 1 write per cycle.
REQ-015 SHALL implement states INIT and RUN; INIT zeroes record init_ptr each cycle, init_ptr counting 0..DEPTH-1.
REQ-016 SHALL move INIT->RUN in the cycle after record DEPTH-1 is zeroed; sweep takes exactly DEPTH cycles.
REQ-017 SHALL drive init_busy high exactly while in INIT.
REQ-018 SHALL ignore wr during INIT; only sweep writes occur.
REQ-019 SHALL force odata to 0 on every INIT cycle.
REQ-020 SHALL in RUN, on wr=1 and addr<DEPTH, update only lanes whose wmask bit is 1; other lanes keep their value.
REQ-021 SHALL in RUN present record[addr] on odata one cycle after addr is sampled (latency 1); odata updates every cycle, independent of wr.
REQ-022 SHALL ignore writes with addr>=DEPTH and return odata=0 for reads with addr>=DEPTH.
REQ-023 SHALL on clear=1 in RUN enter INIT next cycle with init_ptr=0; any write in that same cycle is discarded.
REQ-024 SHALL on clear=1 during INIT restart the sweep from init_ptr=0.
REQ-025 SHALL on wr=1 with wmask=0 leave the array unchanged.

Reset
REQ-026 SHALL on reset=1 at a clock edge set state=INIT, init_ptr=0, odata=0, init_busy=1 next cycle.
REQ-027 SHALL give reset priority over clear and wr.
REQ-028 SHALL on reset asserted mid-sweep or mid-RUN restart the full sweep; array contents are undefined until the sweep completes.

Configuration
REQ-029 SHALL use macro CHANNEL_REGISTER_FILE_BYPASS_EN.
REQ-030 SHALL with the macro defined return merged data on a same-address read-during-write in RUN: masked lanes from idata, other lanes from stored value (write-first).
REQ-031 SHALL with the macro undefined return the pre-write stored value on a same-address read-during-write (read-first).

Verification
REQ-032 SHALL cover reset: reset 1 cycle, defaults -> init_busy high 9 cycles then low; odata=0 throughout; all 9 records read 0 afterwards.
REQ-033 SHALL cover masked write: write 0xABCDEF to addr 3, then wmask=3'b010 idata=0x001200 -> reading addr 3 gives 0xAB12EF one cycle after addr.
REQ-034 SHALL cover read-during-write: record 5=0x111111, write 0x222222 wmask=3'b111 at addr 5 -> odata next cycle 0x222222 with BYPASS_EN, 0x111111 without; the following read gives 0x222222 either way.
REQ-035 SHALL cover out-of-range: write 0xFFFFFF to addr 9 and 15 -> records 0..8 unchanged; odata=0 for those addresses.
REQ-036 SHALL cover clear mid-RUN with simultaneous wr to addr 2 -> write discarded, init_busy high 9 cycles, record 2 reads 0.
REQ-037 SHALL cover reset at sweep cycle 4 and wr during INIT -> sweep restarts, init_busy high 9 further cycles, the INIT-time write absent.

Source files
------------

// File: rtl/channel_register_file.sv
// channel_register_file: DEPTH x DATA_W channel record store.
// - One read and one lane-masked write per cycle.
// - A zeroing sweep (INIT) runs after reset or clear, before normal operation (RUN).
// - Read data is registered, so odata is valid one cycle after addr is sampled.
// Optional build macro: CHANNEL_REGISTER_FILE_BYPASS_EN
//   - defined:   a same-address read-during-write returns the merged record (write-first).
//   - undefined: it returns the pre-write stored record (read-first).
module channel_register_file #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 9,
  parameter int ADDR_W = 4,
  parameter int LANE_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     wr,
  input  logic [DATA_W/LANE_W-1:0] wmask,
  input  logic [DATA_W-1:0]        idata,
  output logic [DATA_W-1:0]        odata,
  output logic                     init_busy
);

  localparam int NLANES = DATA_W / LANE_W;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   init_ptr_r;
  logic [ADDR_W-1:0]   init_ptr_nxt_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DATA_W-1:0]   odata_r;
  logic                init_busy_r;

  logic                addr_ok_s;
  logic [ADDR_W-1:0]   rd_idx_s;
  logic [DATA_W-1:0]   stored_s;
  logic [DATA_W-1:0]   merged_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   wr_idx_s;
  logic [DATA_W-1:0]   wr_data_s;

  // Replace the lanes selected by mask with the matching lanes of new_rec.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_rec,
    input logic [DATA_W-1:0] new_rec,
    input logic [NLANES-1:0] mask
  );
    logic [DATA_W-1:0] res;
    res = old_rec;
    for (int i = 0; i < NLANES; i++) begin
      if (mask[i]) begin
        res[i*LANE_W +: LANE_W] = new_rec[i*LANE_W +: LANE_W];
      end else begin
        res[i*LANE_W +: LANE_W] = old_rec[i*LANE_W +: LANE_W];
      end
    end
    return res;
  endfunction

  // Out-of-range addresses are redirected to record 0 so the array is never indexed past DEPTH.
  assign addr_ok_s = ({1'b0, addr} < DEPTH_L);
  assign rd_idx_s  = addr_ok_s ? addr : {ADDR_W{1'b0}};
  assign stored_s  = mem_r[rd_idx_s];
  assign merged_s  = lane_merge(stored_s, idata, wmask);

  // Sequencing: the sweep pointer and the next state, plus the single array write port.
  always_comb begin
    state_nxt_s    = state_r;
    init_ptr_nxt_s = init_ptr_r;
    wr_en_s        = 1'b0;
    wr_idx_s       = init_ptr_r;
    wr_data_s      = {DATA_W{1'b0}};
    case (state_r)
      INIT: begin
        // The sweep owns the write port; user writes are ignored.
        wr_en_s   = 1'b1;
        wr_idx_s  = init_ptr_r;
        wr_data_s = {DATA_W{1'b0}};
        if (clear) begin
          init_ptr_nxt_s = {ADDR_W{1'b0}};
        end else if (init_ptr_r == LAST_PTR) begin
          state_nxt_s    = RUN;
          init_ptr_nxt_s = {ADDR_W{1'b0}};
        end else begin
          init_ptr_nxt_s = init_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (clear) begin
          // The write arriving with clear is dropped.
          state_nxt_s    = INIT;
          init_ptr_nxt_s = {ADDR_W{1'b0}};
        end else if (wr && addr_ok_s) begin
          wr_en_s   = 1'b1;
          wr_idx_s  = addr;
          wr_data_s = merged_s;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s    = INIT;
        init_ptr_nxt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Read data for the RUN state; the same-address collision policy depends on the build macro.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    if (!addr_ok_s) begin
      rd_data_s = {DATA_W{1'b0}};
`ifdef CHANNEL_REGISTER_FILE_BYPASS_EN
    end else if (wr && !clear) begin
      rd_data_s = merged_s;
`endif
    end else begin
      rd_data_s = stored_s;
    end
  end

  // State register and sweep pointer; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= INIT;
      init_ptr_r <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      init_ptr_r <= init_ptr_nxt_s;
    end
  end

  // Record array write port; no writes occur while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_s) begin
      mem_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Registered outputs: odata holds 0 throughout the sweep; busy follows the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      odata_r     <= {DATA_W{1'b0}};
      init_busy_r <= 1'b1;
    end else begin
      init_busy_r <= (state_nxt_s == INIT);
      if ((state_r == INIT) || clear) begin
        odata_r <= {DATA_W{1'b0}};
      end else begin
        odata_r <= rd_data_s;
      end
    end
  end

  assign odata     = odata_r;
  assign init_busy = init_busy_r;

endmodule

// File: tb/tb_channel_register_file.sv
// Self-checking bench for channel_register_file (default parameters).
// Honours CHANNEL_REGISTER_FILE_BYPASS_EN for the collision expectation.
module tb_channel_register_file;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 9;
  localparam int ADDR_W = 4;
  localparam int LANE_W = 8;
  localparam int NLANES = DATA_W / LANE_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clear = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              wr = 1'b0;
  logic [NLANES-1:0] wmask = '0;
  logic [DATA_W-1:0] idata = '0;
  logic [DATA_W-1:0] odata;
  logic              init_busy;

  int errors = 0;
  int checks = 0;

  // Reference model: record contents plus number of sweep cycles still to run.
  logic [DATA_W-1:0] model [DEPTH];
  int                remaining = 0;
  logic [DATA_W-1:0] exp_odata = '0;
  logic              exp_busy = 1'b1;
`ifdef CHANNEL_REGISTER_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  channel_register_file #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LANE_W(LANE_W)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .addr(addr), .wr(wr),
    .wmask(wmask), .idata(idata), .odata(odata), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [NLANES-1:0] m);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < NLANES; i++)
      if (m[i]) r[i*LANE_W +: LANE_W] = new_v[i*LANE_W +: LANE_W];
    return r;
  endfunction

  // Apply one clock of stimulus and advance the model; outputs are settled on return.
  task automatic step(input logic r, input logic c, input logic [ADDR_W-1:0] a,
                      input logic w, input logic [NLANES-1:0] m, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] mg;
    reset = r; clear = c; addr = a; wr = w; wmask = m; idata = d;
    @(posedge clk);
    if (r) begin
      remaining = DEPTH; exp_odata = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (remaining > 0) begin
      remaining = c ? DEPTH : remaining - 1;
      exp_odata = '0;
    end else if (c) begin
      remaining = DEPTH; exp_odata = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (int'(a) < DEPTH) begin
      mg = merge(model[a], d, m);
      exp_odata = (BYPASS && w) ? mg : model[a];
      if (w) model[a] = mg;
    end else begin
      exp_odata = '0;
    end
    exp_busy = (remaining > 0);
    #1;
    reset = 1'b0; clear = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    int hi;
    step(1'b1, 1'b0, 4'd0, 1'b0, 3'b000, 24'h0);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (init_busy !== exp_busy || odata !== 24'h0) begin
        errors++;
        $display("FAIL reset_sweep k=%0d busy=%b odata=%h want busy=%b odata=000000", k, init_busy, odata, exp_busy);
      end
      if (init_busy === 1'b1) hi++;
      if (init_busy !== 1'b1) break;
      step(1'b0, 1'b0, 4'd0, 1'b0, 3'b000, 24'h0);
    end
    checks++;
    if (hi != 9) begin errors++; $display("FAIL reset_busy_len got=%0d want=9", hi); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b0, 1'b0, ADDR_W'(i % DEPTH), 1'b0, 3'b000, 24'h0);
      if (i > 0) begin
        checks++;
        if (odata !== 24'h0 || odata !== exp_odata) begin
          errors++; $display("FAIL reset_zero addr=%0d got=%h want=000000", i % DEPTH, odata);
        end
      end
    end
  endtask

  task automatic test_masked_write();
    step(1'b0, 1'b0, 4'd3, 1'b1, 3'b111, 24'hABCDEF);
    step(1'b0, 1'b0, 4'd3, 1'b1, 3'b010, 24'h001200);
    checks++;
    if (odata !== exp_odata) begin errors++; $display("FAIL mask_collide got=%h want=%h", odata, exp_odata); end
    step(1'b0, 1'b0, 4'd3, 1'b0, 3'b000, 24'h0);
    checks++;
    if (odata !== 24'hAB12EF) begin errors++; $display("FAIL masked_write got=%h want=ab12ef", odata); end
    step(1'b0, 1'b0, 4'd3, 1'b1, 3'b000, 24'h5A5A5A);
    step(1'b0, 1'b0, 4'd3, 1'b0, 3'b000, 24'h0);
    checks++;
    if (odata !== 24'hAB12EF) begin errors++; $display("FAIL zero_mask got=%h want=ab12ef", odata); end
  endtask

  task automatic test_read_during_write();
    logic [DATA_W-1:0] want;
    step(1'b0, 1'b0, 4'd5, 1'b1, 3'b111, 24'h111111);
    step(1'b0, 1'b0, 4'd5, 1'b1, 3'b111, 24'h222222);
    want = BYPASS ? 24'h222222 : 24'h111111;
    checks++;
    if (odata !== want || odata !== exp_odata) begin
      errors++; $display("FAIL rdw_collide got=%h want=%h", odata, want);
    end
    step(1'b0, 1'b0, 4'd5, 1'b0, 3'b000, 24'h0);
    checks++;
    if (odata !== 24'h222222) begin errors++; $display("FAIL rdw_after got=%h want=222222", odata); end
  endtask

  task automatic test_out_of_range();
    step(1'b0, 1'b0, 4'd9, 1'b1, 3'b111, 24'hFFFFFF);
    checks++;
    if (odata !== 24'h0) begin errors++; $display("FAIL oor_addr9 got=%h want=000000", odata); end
    step(1'b0, 1'b0, 4'd15, 1'b1, 3'b111, 24'hFFFFFF);
    checks++;
    if (odata !== 24'h0) begin errors++; $display("FAIL oor_addr15 got=%h want=000000", odata); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, ADDR_W'(i), 1'b0, 3'b000, 24'h0);
      checks++;
      if (odata !== exp_odata) begin
        errors++; $display("FAIL oor_intact addr=%0d got=%h want=%h", i, odata, exp_odata);
      end
    end
  endtask

  // Shared by the clear and mid-sweep reset scenarios: walk the sweep with wr held on addr a.
  task automatic run_sweep(input string tag, input logic [ADDR_W-1:0] a, output int hi);
    hi = (init_busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 20 && init_busy === 1'b1; k++) begin
      step(1'b0, 1'b0, a, 1'b1, 3'b111, 24'hC3C3C3);
      checks++;
      if (init_busy !== exp_busy || (exp_busy && odata !== 24'h0)) begin
        errors++; $display("FAIL %s k=%0d busy=%b odata=%h want busy=%b", tag, k, init_busy, odata, exp_busy);
      end
      if (init_busy === 1'b1) hi++;
    end
  endtask

  task automatic test_clear_mid_run();
    int hi;
    step(1'b0, 1'b0, 4'd2, 1'b1, 3'b111, 24'h123456);
    step(1'b0, 1'b1, 4'd2, 1'b1, 3'b111, 24'hABCDEF);
    run_sweep("clear_sweep", 4'd7, hi);
    checks++;
    if (hi != 9) begin errors++; $display("FAIL clear_busy_len got=%0d want=9", hi); end
    step(1'b0, 1'b0, 4'd2, 1'b0, 3'b000, 24'h0);
    checks++;
    if (odata !== 24'h0) begin errors++; $display("FAIL clear_rec2 got=%h want=000000", odata); end
  endtask

  task automatic test_reset_mid_sweep();
    int hi;
    step(1'b0, 1'b0, 4'd1, 1'b1, 3'b111, 24'h777777);
    step(1'b1, 1'b0, 4'd0, 1'b0, 3'b000, 24'h0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4'd1, 1'b1, 3'b111, 24'h5A5A5A);
    checks++;
    if (init_busy !== 1'b1) begin errors++; $display("FAIL midsweep_busy got=%b want=1", init_busy); end
    step(1'b1, 1'b0, 4'd1, 1'b1, 3'b111, 24'h5A5A5A);
    run_sweep("reset_resweep", 4'd1, hi);
    checks++;
    if (hi != 9) begin errors++; $display("FAIL resweep_busy_len got=%0d want=9", hi); end
    step(1'b0, 1'b0, 4'd1, 1'b0, 3'b000, 24'h0);
    checks++;
    if (odata !== 24'h0) begin errors++; $display("FAIL init_write_absent got=%h want=000000", odata); end
  endtask

  task automatic test_random();
    logic r, c;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 149) == 0);
      c = ($urandom_range(0, 59) == 0);
      step(r, c, ADDR_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           NLANES'($urandom), DATA_W'($urandom));
      checks++;
      if (odata !== exp_odata || init_busy !== exp_busy) begin
        errors++;
        $display("FAIL random k=%0d odata=%h busy=%b want odata=%h busy=%b", k, odata, init_busy, exp_odata, exp_busy);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_masked_write();
    test_read_during_write();
    test_out_of_range();
    test_clear_mid_run();
    test_reset_mid_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
